dmem_bus_ctrl: RTL

- Sits directly downstream of the single-cycle core's execute stage, between the ALU result/store-data path and a slower word-wide data memory with a req/ack handshake.
- Converts core loads and stores (byte, halfword, word; signed or unsigned) into word-aligned bus transactions with byte enables.
- Holds the core with a stall signal until the access completes.
- Detects misaligned accesses and bus timeouts.

---
 rtl/dmem_bus_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: core load/store to word-wide req/ack bus bridge with big-endian lanes, stall, misalign and timeout detection
module dmem_bus_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  size,
    input  logic        sign_ld,
    input  logic [31:0] address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        done,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t state_q, state_d;
    logic req_q, req_d, we_q, we_d, sign_q, sign_d, aerr_q, aerr_d, berr_q, berr_d;
    logic [1:0] off_q, off_d, size_q, size_d;
    logic [3:0] be_q, be_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic acc, mis, to_hit;
    logic [3:0] be_n;
    logic [31:0] wd_n, ext;
    logic [7:0] byte_l;
    logic [15:0] half_l;
    logic [CNT_W-1:0] cnt_inc;

    assign acc = MemRead | MemWrite;
    assign mis = (size == 2'b11) | ((size == 2'b01) & address[0]) | ((size == 2'b10) & |address[1:0]);
    assign be_n = size == 2'b00 ? 4'b1000 >> address[1:0] : size == 2'b01 ? (address[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    assign wd_n = size == 2'b00 ? {4{WriteData[7:0]}} : size == 2'b01 ? {2{WriteData[15:0]}} : WriteData;
    // offset 0 is the most significant lane, so shift right by (3 - offset) bytes
    assign byte_l = 8'(mem_rdata >> {~off_q, 3'b000});
    assign half_l = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    assign ext = size_q == 2'b00 ? {{24{sign_q & byte_l[7]}}, byte_l}
               : size_q == 2'b01 ? {{16{sign_q & half_l[15]}}, half_l} : mem_rdata;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign to_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
    assign done = state_q == DONE;
    assign stall = acc & ~done;
    assign addr_err = aerr_q;
    assign bus_err = berr_q;
    assign mem_req = req_q;
    assign mem_we = we_q;
    assign mem_addr = addr_q;
    assign mem_be = be_q;
    assign mem_wdata = wdata_q;
    assign ReadData = rdata_q;

    always_comb begin
        state_d = state_q;
        req_d = req_q;
        we_d = we_q;
        addr_d = addr_q;
        be_d = be_q;
        wdata_d = wdata_q;
        off_d = off_q;
        size_d = size_q;
        sign_d = sign_q;
        rdata_d = rdata_q;
        cnt_d = '0;
        aerr_d = 1'b0;
        berr_d = 1'b0;
        case (state_q)
            IDLE: if (acc) begin
                rdata_d = '0;
                if (mis) begin
                    state_d = DONE;
                    aerr_d = 1'b1;
                end else begin
                    state_d = BUS;
                    req_d = 1'b1;
                    we_d = MemWrite;
                    addr_d = {address[31:2], 2'b00};
                    be_d = be_n;
                    wdata_d = wd_n;
                    off_d = address[1:0];
                    size_d = size;
                    sign_d = sign_ld;
                end
            end
            BUS: begin
                cnt_d = cnt_inc;
                if (mem_ack | to_hit) begin
                    state_d = DONE;
                    req_d = 1'b0;
                    we_d = 1'b0;
                    berr_d = ~mem_ack;
                    rdata_d = (mem_ack & ~we_q) ? ext : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            req_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            be_q <= '0;
            wdata_q <= '0;
            off_q <= '0;
            size_q <= '0;
            sign_q <= 1'b0;
            rdata_q <= '0;
            cnt_q <= '0;
            aerr_q <= 1'b0;
            berr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            we_q <= we_d;
            addr_q <= addr_d;
            be_q <= be_d;
            wdata_q <= wdata_d;
            off_q <= off_d;
            size_q <= size_d;
            sign_q <= sign_d;
            rdata_q <= rdata_d;
            cnt_q <= cnt_d;
            aerr_q <= aerr_d;
            berr_q <= berr_d;
        end
    end
endmodule
